pi_accumulator: RTL and testbench
=================================

PI_ACCUMULATOR -- requirements
Module: pi_accumulator

Interface
REQ-001 SHALL have parameter CENTER, default 240: circle centre coordinate on both axes.
REQ-002 SHALL have parameter RADIUS, default 240: circle radius; the square is the range 0..2*RADIUS on each axis.
REQ-003 SHALL have port clk10  input  1: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port pt_valid  input  1: random point offered, from the LFSR point source.
REQ-006 SHALL have port pt_x  input  9: point X coordinate.
REQ-007 SHALL have port pt_y  input  9: point Y coordinate.
REQ-008 SHALL have port pt_ready  output  1: block accepts a point this cycle.
REQ-009 SHALL have port inside_cnt  output  16: count of accepted points inside the circle.
REQ-010 SHALL have port total_cnt  output  16: count of accepted in-square points.
REQ-011 SHALL have port est_q  output  16: pi estimate, unsigned Q3.13 (4*inside/total).
REQ-012 SHALL have port est_valid  output  1: one-cycle pulse when est_q updates.
REQ-013 SHALL have port drop  output  1: one-cycle pulse when an out-of-square point is discarded.
REQ-014 SHALL have port sat  output  1: total_cnt has reached 16'hFFFF; counting frozen.

Function
REQ-015 SHALL implement the states IDLE, SQ, ACC and DIV; pt_ready SHALL be 1 only in IDLE with sat=0.
REQ-016 Handshake: a point is accepted on an edge where pt_valid=1 and pt_ready=1; pt_x and pt_y are sampled on that edge only.
REQ-017 An accepted point with pt_x>2*RADIUS or pt_y>2*RADIUS SHALL be discarded: drop=1 the next cycle, state stays IDLE, counters unchanged, no est_valid.
REQ-018 For an in-square point, IDLE->SQ SHALL register dx=|pt_x-CENTER| and dy=|pt_y-CENTER|.
REQ-019 SQ->ACC SHALL register sum=dx*dx+dy*dy, 18 bits, with no truncation.
REQ-020 ACC->DIV SHALL increment total_cnt, and SHALL also increment inside_cnt when sum<=RADIUS*RADIUS; the boundary counts as inside.
REQ-021 DIV SHALL run a 16-iteration restoring division of (inside_cnt<<15) by total_cnt, one quotient bit per cycle, using the post-update counts.
REQ-022 After the 16th DIV cycle, est_q SHALL load the quotient, est_valid SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-023 Latency: an accept on edge E0 SHALL give est_valid=1 in the cycle after edge E18; pt_ready=0 from E0 until IDLE is re-entered.
REQ-024 inside_cnt<=total_cnt always, so est_q<=16'h8000 and never overflows.
REQ-025 When total_cnt becomes 16'hFFFF in ACC, sat SHALL assert and stay 1 until reset; the final division still completes.
REQ-026 While sat=1, pt_ready SHALL be 0 and no further counting or drop pulses SHALL occur.
REQ-027 est_q SHALL hold its value between updates.

Reset
REQ-028 Reset SHALL force state IDLE, inside_cnt=0, total_cnt=0, est_q=0, est_valid=0, drop=0 and sat=0.
REQ-029 Reset asserted in any state, including mid-DIV, SHALL abort the operation; no est_valid pulse follows and pt_ready=1 in the cycle after reset deasserts.

Configuration
REQ-030 Macro PI_ACC_ROUND_EN: when defined, the quotient SHALL be floor(((inside<<15)+(total>>1))/total), i.e. round-to-nearest; when undefined, the quotient SHALL be truncated, floor((inside<<15)/total).
REQ-031 The DIV cycle count, and therefore the latency, SHALL be identical with and without PI_ACC_ROUND_EN.

Verification
REQ-032 Reset, then point (240,240) -> inside=1, total=1, est_q=16'h8000 on the cycle after E18.
REQ-033 Then point (0,0), sum=115200 -> inside=1, total=2, est_q=16'h4000.
REQ-034 Then point (480,240), sum=57600 on the boundary -> inside=2, total=3; est_q=21845 truncated, or 21845 with PI_ACC_ROUND_EN.
REQ-035 Point (481,10) -> drop pulse next cycle, counts unchanged, no est_valid, pt_ready stays 1.
REQ-036 Sequence inside=1, total=3 -> est_q=10922 without PI_ACC_ROUND_EN, 10923 with it.
REQ-037 Reset pulse 5 cycles into DIV -> no est_valid, all outputs 0; preload total=16'hFFFE and accept a point -> sat=1 and pt_ready held at 0.

Source files
------------

// File: rtl/pi_accumulator.sv
// pi_accumulator: Monte-Carlo pi estimator.
// Random points arrive from an LFSR source. Each in-square point is classified
// as inside or outside the circle and added to the running counts. A 16-cycle
// restoring divider then refreshes est_q = 4*inside/total as unsigned Q3.13.
// Optional feature macro: PI_ACC_ROUND_EN (round-to-nearest quotient instead of truncation).
//
// Handshake (pt_valid/pt_ready): a point transfers on a rising clk10 edge where
// pt_valid=1 and pt_ready=1. pt_x/pt_y are sampled on that edge only. While
// pt_ready=0 the source may hold or change its offer and nothing is sampled.
module pi_accumulator #(
  parameter int CENTER = 240,
  parameter int RADIUS = 240
) (
  input  logic        clk10,
  input  logic        reset,
  input  logic        pt_valid,
  input  logic [8:0]  pt_x,
  input  logic [8:0]  pt_y,
  output logic        pt_ready,
  output logic [15:0] inside_cnt,
  output logic [15:0] total_cnt,
  output logic [15:0] est_q,
  output logic        est_valid,
  output logic        drop,
  output logic        sat,
  output logic [1:0]  o_dbg_state
);

  localparam logic [9:0]  SQ_MAX = 10'(2 * RADIUS);
  localparam logic [8:0]  CTR    = 9'(CENTER);
  localparam logic [17:0] R_SQ   = 18'(RADIUS * RADIUS);

  typedef enum logic [1:0] {IDLE = 2'd0, SQ = 2'd1, ACC = 2'd2, DIV = 2'd3} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_dx;
  logic [8:0]  r_dy;
  logic [17:0] r_sum;
  logic [15:0] r_inside_cnt;
  logic [15:0] r_total_cnt;
  logic [15:0] r_est_q;
  logic        r_est_valid;
  logic        r_drop;
  logic        r_sat;
  logic [15:0] r_rem;
  logic [15:0] r_dvd;
  logic [15:0] r_quo;
  logic [3:0]  r_cnt;

  logic        w_ready;
  logic        w_accept;
  logic        w_in_sq;
  logic [8:0]  w_dx;
  logic [8:0]  w_dy;
  logic [17:0] w_sq_sum;
  logic        w_hit;
  logic [15:0] w_ins_nxt;
  logic [15:0] w_tot_nxt;
  logic [30:0] w_dvd_init;
  logic [16:0] w_trial;
  logic        w_ge;
  logic [15:0] w_rem_nxt;
  logic [15:0] w_quo_nxt;
  logic        w_last;

  // Point classification and distance from the centre, taken straight off the inputs.
  assign w_in_sq  = ({1'b0, pt_x} <= SQ_MAX) && ({1'b0, pt_y} <= SQ_MAX);
  assign w_dx     = (pt_x >= CTR) ? (pt_x - CTR) : (CTR - pt_x);
  assign w_dy     = (pt_y >= CTR) ? (pt_y - CTR) : (CTR - pt_y);
  assign w_accept = w_ready & pt_valid;
  assign w_sq_sum = ({9'd0, r_dx} * {9'd0, r_dx}) + ({9'd0, r_dy} * {9'd0, r_dy});

  // Post-update counts feed the divider directly so DIV sees the new ratio.
  assign w_hit     = (r_sum <= R_SQ);
  assign w_ins_nxt = r_inside_cnt + {15'd0, w_hit};
  assign w_tot_nxt = r_total_cnt + 16'd1;
`ifdef PI_ACC_ROUND_EN
  assign w_dvd_init = {w_ins_nxt, 15'd0} + {16'd0, w_tot_nxt[15:1]};
`else
  assign w_dvd_init = {w_ins_nxt, 15'd0};
`endif

  // One restoring-division step. The remainder always stays below total_cnt, so 16 bits hold it.
  assign w_trial   = {r_rem, r_dvd[15]};
  assign w_ge      = (w_trial >= {1'b0, r_total_cnt});
  assign w_rem_nxt = w_ge ? 16'(w_trial - {1'b0, r_total_cnt}) : w_trial[15:0];
  assign w_quo_nxt = {r_quo[14:0], w_ge};
  assign w_last    = (r_cnt == 4'd15);

  // FSM state register.
  always_ff @(posedge clk10) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and ready; only IDLE without saturation accepts points.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = !r_sat;
        if (pt_valid && !r_sat && w_in_sq) w_state_nxt = SQ;
      end
      SQ:      w_state_nxt = ACC;
      ACC:     w_state_nxt = DIV;
      DIV:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: distance capture, squaring, counting, division and result pulses.
  always_ff @(posedge clk10) begin
    if (reset) begin
      r_dx         <= '0;
      r_dy         <= '0;
      r_sum        <= '0;
      r_inside_cnt <= '0;
      r_total_cnt  <= '0;
      r_est_q      <= '0;
      r_est_valid  <= 1'b0;
      r_drop       <= 1'b0;
      r_sat        <= 1'b0;
      r_rem        <= '0;
      r_dvd        <= '0;
      r_quo        <= '0;
      r_cnt        <= '0;
    end else begin
      r_est_valid <= 1'b0;
      r_drop      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_in_sq) begin
              r_dx <= w_dx;
              r_dy <= w_dy;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        SQ: r_sum <= w_sq_sum;
        ACC: begin
          r_total_cnt  <= w_tot_nxt;
          r_inside_cnt <= w_ins_nxt;
          if (w_tot_nxt == 16'hFFFF) r_sat <= 1'b1;
          r_rem <= {1'b0, w_dvd_init[30:16]};
          r_dvd <= w_dvd_init[15:0];
          r_quo <= '0;
          r_cnt <= '0;
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[14:0], 1'b0};
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_est_q     <= w_quo_nxt;
            r_est_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pt_ready    = w_ready;
  assign inside_cnt  = r_inside_cnt;
  assign total_cnt   = r_total_cnt;
  assign est_q       = r_est_q;
  assign est_valid   = r_est_valid;
  assign drop        = r_drop;
  assign sat         = r_sat;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pi_accumulator.sv
// tb_pi_accumulator: directed and random points against an arithmetic model of
// the pi estimator; expected estimates queue up when a point is driven and are
// checked when est_valid fires.
module tb_pi_accumulator;

  localparam int CENTER = 240;
  localparam int RADIUS = 240;

  logic        clk10 = 1'b0;
  logic        reset;
  logic        pt_valid;
  logic [8:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_ready;
  logic [15:0] inside_cnt;
  logic [15:0] total_cnt;
  logic [15:0] est_q;
  logic        est_valid;
  logic        drop;
  logic        sat;
  logic [1:0]  o_dbg_state;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  int          m_inside;
  int          m_total;
  logic [15:0] m_est;
  logic        m_sat;
  logic [15:0] got;

  pi_accumulator #(.CENTER(CENTER), .RADIUS(RADIUS)) dut (
    .clk10(clk10), .reset(reset), .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y),
    .pt_ready(pt_ready), .inside_cnt(inside_cnt), .total_cnt(total_cnt),
    .est_q(est_q), .est_valid(est_valid), .drop(drop), .sat(sat),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog.
  always #5 clk10 = ~clk10;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_est(input int ins, input int tot);
    longint num;
    num = longint'(ins) << 15;
`ifdef PI_ACC_ROUND_EN
    num = num + longint'(tot / 2);
`endif
    return 16'(num / longint'(tot));
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    pt_valid = 1'b0;
    pt_x     = '0;
    pt_y     = '0;
    repeat (3) @(negedge clk10);
    reset    = 1'b0;
    m_inside = 0;
    m_total  = 0;
    m_est    = '0;
    m_sat    = 1'b0;
    exp_q.delete();
  endtask

  // Driver: offers one point, then checks drop or the full estimate update.
  task automatic send_point(input logic [8:0] x, input logic [8:0] y, output logic [15:0] got_est);
    int   waited;
    int   lat;
    int   ready_bad;
    int   dx;
    int   dy;
    logic in_sq;
    logic [15:0] exp_est;
    got_est = 16'hDEAD;
    waited  = 0;
    while (pt_ready !== 1'b1 && waited < 40) begin
      @(negedge clk10);
      waited++;
    end
    if (pt_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_wait: pt_ready=%b want 1", pt_ready);
      return;
    end
    in_sq = (int'(x) <= 2 * RADIUS) && (int'(y) <= 2 * RADIUS);
    pt_x = x;
    pt_y = y;
    pt_valid = 1'b1;
    @(negedge clk10);
    pt_valid = 1'b0;
    if (!in_sq) begin
      n_checks++;
      if (drop !== 1'b1 || pt_ready !== 1'b1 || est_valid !== 1'b0) begin
        $display("FAIL drop_pulse (%0d,%0d): drop=%b ready=%b est_valid=%b want 1 1 0", x, y, drop, pt_ready, est_valid);
      end else n_pass++;
      n_checks++;
      if (inside_cnt !== 16'(m_inside) || total_cnt !== 16'(m_total) || est_q !== m_est) begin
        $display("FAIL drop_hold: inside=%0d total=%0d est=%0d want %0d %0d %0d", inside_cnt, total_cnt, est_q, m_inside, m_total, m_est);
      end else n_pass++;
      @(negedge clk10);
      n_checks++;
      if (drop !== 1'b0 || est_valid !== 1'b0) begin
        $display("FAIL drop_width: drop=%b est_valid=%b want 0 0", drop, est_valid);
      end else n_pass++;
      return;
    end
    dx = int'(x) - CENTER;
    if (dx < 0) dx = -dx;
    dy = int'(y) - CENTER;
    if (dy < 0) dy = -dy;
    m_total++;
    if (dx * dx + dy * dy <= RADIUS * RADIUS) m_inside++;
    exp_q.push_back(model_est(m_inside, m_total));
    m_sat = (m_total == 65535);
    lat = -1;
    ready_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk10);
      if (est_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (pt_ready !== 1'b0) ready_bad++;
    end
    n_checks++;
    if (lat != 18) $display("FAIL latency: est_valid after %0d edges want 18", lat);
    else n_pass++;
    exp_est = exp_q.pop_front();
    if (lat < 0) return;
    got_est = est_q;
    n_checks++;
    if (est_q !== exp_est) $display("FAIL est_q (%0d,%0d): got %0d want %0d", x, y, est_q, exp_est);
    else n_pass++;
    n_checks++;
    if (inside_cnt !== 16'(m_inside) || total_cnt !== 16'(m_total)) begin
      $display("FAIL counts: inside=%0d total=%0d want %0d %0d", inside_cnt, total_cnt, m_inside, m_total);
    end else n_pass++;
    n_checks++;
    if (ready_bad != 0 || pt_ready !== !m_sat) begin
      $display("FAIL busy_ready: busy-high cycles=%0d ready=%b want 0 %b", ready_bad, pt_ready, !m_sat);
    end else n_pass++;
    m_est = exp_est;
    @(negedge clk10);
    n_checks++;
    if (est_valid !== 1'b0 || pt_ready !== !m_sat || sat !== m_sat || est_q !== m_est) begin
      $display("FAIL post_est: est_valid=%b ready=%b sat=%b est=%0d want 0 %b %b %0d", est_valid, pt_ready, sat, est_q, !m_sat, m_sat, m_est);
    end else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk10);
    n_checks++;
    if (inside_cnt !== 16'd0 || total_cnt !== 16'd0 || est_q !== 16'd0) begin
      $display("FAIL reset_counts: inside=%0d total=%0d est=%0d want 0 0 0", inside_cnt, total_cnt, est_q);
    end else n_pass++;
    n_checks++;
    if (est_valid !== 1'b0 || drop !== 1'b0 || sat !== 1'b0 || pt_ready !== 1'b1 || o_dbg_state !== 2'd0) begin
      $display("FAIL reset_flags: ev=%b drop=%b sat=%b ready=%b state=%0d want 0 0 0 1 0", est_valid, drop, sat, pt_ready, o_dbg_state);
    end else n_pass++;
  endtask

  task automatic test_directed();
    do_reset();
    send_point(9'd240, 9'd240, got);
    n_checks++;
    if (got !== 16'h8000) $display("FAIL centre_est: got %h want 8000", got);
    else n_pass++;
    send_point(9'd0, 9'd0, got);
    n_checks++;
    if (got !== 16'h4000) $display("FAIL corner_est: got %h want 4000", got);
    else n_pass++;
    send_point(9'd480, 9'd240, got);
    n_checks++;
    if (got !== 16'd21845 || inside_cnt !== 16'd2) $display("FAIL boundary_est: got %0d inside=%0d want 21845 2", got, inside_cnt);
    else n_pass++;
  endtask

  task automatic test_drop();
    send_point(9'd481, 9'd10, got);
    send_point(9'd10, 9'd481, got);
  endtask

  task automatic test_one_third();
    logic [15:0] want;
`ifdef PI_ACC_ROUND_EN
    want = 16'd10923;
`else
    want = 16'd10922;
`endif
    do_reset();
    send_point(9'd240, 9'd240, got);
    send_point(9'd0, 9'd0, got);
    send_point(9'd0, 9'd480, got);
    n_checks++;
    if (got !== want) $display("FAIL one_third_est: got %0d want %0d", got, want);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      send_point(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), got);
    end
  endtask

  task automatic test_reset_mid_div();
    int bad;
    do_reset();
    pt_x = 9'd240;
    pt_y = 9'd240;
    pt_valid = 1'b1;
    @(negedge clk10);
    pt_valid = 1'b0;
    repeat (7) @(negedge clk10);
    n_checks++;
    if (o_dbg_state !== 2'd3) $display("FAIL mid_div_state: state=%0d want 3", o_dbg_state);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk10);
    reset = 1'b0;
    n_checks++;
    if (inside_cnt !== 16'd0 || total_cnt !== 16'd0 || est_q !== 16'd0 || sat !== 1'b0 || drop !== 1'b0 || est_valid !== 1'b0) begin
      $display("FAIL abort_outputs: inside=%0d total=%0d est=%0d sat=%b drop=%b ev=%b want all 0", inside_cnt, total_cnt, est_q, sat, drop, est_valid);
    end else n_pass++;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk10);
      if (est_valid !== 1'b0 || pt_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_quiet: bad cycles=%0d want 0", bad);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int bad;
    do_reset();
    force dut.r_total_cnt = 16'hFFFE;
    @(negedge clk10);
    release dut.r_total_cnt;
    @(negedge clk10);
    m_total = 65534;
    n_checks++;
    if (total_cnt !== 16'hFFFE || sat !== 1'b0) $display("FAIL preload: total=%h sat=%b want fffe 0", total_cnt, sat);
    else n_pass++;
    send_point(9'd240, 9'd240, got);
    n_checks++;
    if (sat !== 1'b1 || pt_ready !== 1'b0 || total_cnt !== 16'hFFFF) begin
      $display("FAIL sat_set: sat=%b ready=%b total=%h want 1 0 ffff", sat, pt_ready, total_cnt);
    end else n_pass++;
    bad = 0;
    pt_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pt_x = (k < 10) ? 9'd481 : 9'd240;
      pt_y = (k < 10) ? 9'd10  : 9'd240;
      @(negedge clk10);
      if (pt_ready !== 1'b0 || drop !== 1'b0 || est_valid !== 1'b0 || sat !== 1'b1 ||
          total_cnt !== 16'hFFFF || inside_cnt !== 16'd1 || est_q !== m_est) bad++;
    end
    pt_valid = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL sat_frozen: bad cycles=%0d want 0", bad);
    else n_pass++;
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_directed();
    test_drop();
    test_one_third();
    test_random();
    test_reset_mid_div();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
